// File: rtl/svc_rv_io_timer_pkg.sv
// svc_rv_io_timer_pkg: register map offsets and bit positions for the IO timer
package svc_rv_io_timer_pkg;
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_STATUS   = 3'd1;
  localparam logic [2:0] REG_PRESCALE = 3'd2;
  localparam logic [2:0] REG_LOAD     = 3'd3;
  localparam logic [2:0] REG_COUNT    = 3'd4;
  localparam logic [2:0] REG_SCRATCH  = 3'd5;
  localparam int CTRL_EN        = 0;
  localparam int CTRL_PERIODIC  = 1;
  localparam int CTRL_IRQ_EN    = 2;
  localparam int STATUS_EXPIRED = 0;
endpackage

// File: rtl/svc_rv_io_timer_prescaler.sv
// svc_rv_io_timer_prescaler: divides clk into a tick every prescale+1 enabled cycles
module svc_rv_io_timer_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  restart,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);
  logic [PRESCALE_W-1:0] pcnt;
  // >= keeps the divider from running the full range if prescale is lowered mid-count
  assign tick = en & (pcnt >= prescale);
  always_ff @(posedge clk or posedge rst)
    if (rst) pcnt <= '0;
    else pcnt <= (!en || restart || tick) ? '0 : pcnt + 1'b1;
endmodule

// File: rtl/svc_rv_io_timer.sv
// svc_rv_io_timer: memory-mapped prescaled down-counter with one-shot/periodic modes and irq
module svc_rv_io_timer
  import svc_rv_io_timer_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int AW         = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   io_raddr,
  output logic [XLEN-1:0] io_rdata,
  input  logic            io_wen,
  input  logic [AW-1:0]   io_waddr,
  input  logic [XLEN-1:0] io_wdata,
  input  logic [XLEN/8-1:0] io_wstrb,
  output logic            irq,
  output logic            tick
);
  logic [2:0] ctrl, ctrl_nxt;
  logic expired, expired_nxt, expire, restart, w1c;
  logic [PRESCALE_W-1:0] prescale;
  logic [XLEN-1:0] load, count, scratch, count_nxt, prescale_m, rd_val;
  logic [2:0] wa;
  logic unused_ok;

  function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] old, input logic [XLEN-1:0] wd,
                                            input logic [XLEN/8-1:0] st);
    logic [XLEN-1:0] r;
    r = old;
    for (int i = 0; i < XLEN/8; i++) if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  assign wa         = io_waddr[4:2];
  assign expire     = tick && count == '0;
  assign w1c        = io_wen && wa == REG_STATUS && io_wstrb[0] && io_wdata[STATUS_EXPIRED];
  assign restart    = io_wen && wa == REG_CTRL && io_wstrb[0] && io_wdata[CTRL_EN] && !ctrl[CTRL_EN];
  assign prescale_m = merge({{(XLEN-PRESCALE_W){1'b0}}, prescale}, io_wdata, io_wstrb);
  assign unused_ok  = &{1'b0, io_raddr[1:0], io_raddr[AW-1:5], io_waddr[1:0], io_waddr[AW-1:5],
                        prescale_m[XLEN-1:PRESCALE_W]};

  svc_rv_io_timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (ctrl[CTRL_EN]),
    .restart  (restart),
    .prescale (prescale),
    .tick     (tick)
  );

  // hardware one-shot disable wins over a same-cycle software write of en
  always_comb begin
    ctrl_nxt = (io_wen && wa == REG_CTRL && io_wstrb[0]) ? io_wdata[2:0] : ctrl;
    if (expire && !ctrl[CTRL_PERIODIC]) ctrl_nxt[CTRL_EN] = 1'b0;
    expired_nxt = expire || (expired && !w1c);
    count_nxt = (io_wen && wa == REG_COUNT) ? merge(count, io_wdata, io_wstrb) :
                !tick ? count :
                expire ? (ctrl[CTRL_PERIODIC] ? load : count) : count - 1'b1;
  end

  always_comb begin
    rd_val = '0;
    case (io_raddr[4:2])
      REG_CTRL:     rd_val = {{(XLEN-3){1'b0}}, ctrl};
      REG_STATUS:   rd_val = {{(XLEN-1){1'b0}}, expired};
      REG_PRESCALE: rd_val = {{(XLEN-PRESCALE_W){1'b0}}, prescale};
      REG_LOAD:     rd_val = load;
      REG_COUNT:    rd_val = count;
      REG_SCRATCH:  rd_val = scratch;
      default:      rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ctrl     <= '0;
      expired  <= 1'b0;
      prescale <= '0;
      load     <= '0;
      count    <= '0;
      scratch  <= '0;
      io_rdata <= '0;
      irq      <= 1'b0;
    end else begin
      ctrl     <= ctrl_nxt;
      expired  <= expired_nxt;
      count    <= count_nxt;
      io_rdata <= rd_val;
      irq      <= expired_nxt & ctrl_nxt[CTRL_IRQ_EN];
      if (io_wen && wa == REG_PRESCALE) prescale <= prescale_m[PRESCALE_W-1:0];
      if (io_wen && wa == REG_LOAD) load <= merge(load, io_wdata, io_wstrb);
      if (io_wen && wa == REG_SCRATCH) scratch <= merge(scratch, io_wdata, io_wstrb);
    end
endmodule

// File: tb/tb_svc_rv_io_timer.sv
// tb_svc_rv_io_timer: table vectors plus read scoreboard and multi-cycle timer sequences
module tb_svc_rv_io_timer;
  logic clk = 0, rst = 1;
  logic [7:0] io_raddr = 0, io_waddr = 0;
  logic [31:0] io_wdata = 0, io_rdata;
  logic io_wen = 0;
  logic [3:0] io_wstrb = 0;
  logic irq, tick;
  int n_vec = 0, n_err = 0;
  logic rd_req = 0, rd_req_d = 0;
  logic [31:0] exp_q[$];
  string nm_q[$];

  typedef struct {
    logic        wen;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [7:0]  raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[12];

  always #5 clk = ~clk;

  svc_rv_io_timer dut (
    .clk(clk), .rst(rst), .io_raddr(io_raddr), .io_rdata(io_rdata), .io_wen(io_wen),
    .io_waddr(io_waddr), .io_wdata(io_wdata), .io_wstrb(io_wstrb), .irq(irq), .tick(tick)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) rd_req_d <= rd_req;

  always @(negedge clk)
    if (rd_req_d) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_underflow: got %h expected none", io_rdata);
      end else chk(nm_q.pop_front(), io_rdata, exp_q.pop_front());
    end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    io_wen = 1; io_waddr = a; io_wdata = d; io_wstrb = s;
    cyc();
    io_wen = 0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] e, input string nm);
    io_raddr = a; rd_req = 1;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    cyc();
    rd_req = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1'b1, 8'h14, 32'hFFFF_FFFF, 4'hF, 8'h14, 32'hFFFF_FFFF};
    vt[1]  = '{1'b1, 8'h14, 32'h1234_5678, 4'h5, 8'h14, 32'hFF34_FF78};
    vt[2]  = '{1'b1, 8'h1C, 32'hDEAD_BEEF, 4'hF, 8'h1C, 32'h0};
    vt[3]  = '{1'b1, 8'h08, 32'hABCD_1234, 4'hF, 8'h08, 32'h0000_1234};
    vt[4]  = '{1'b1, 8'h0C, 32'hCAFE_F00D, 4'h3, 8'h0C, 32'h0000_F00D};
    vt[5]  = '{1'b1, 8'h10, 32'h0000_0055, 4'h1, 8'h10, 32'h0000_0055};
    vt[6]  = '{1'b1, 8'h00, 32'hFFFF_FFF6, 4'h1, 8'h00, 32'h6};
    vt[7]  = '{1'b1, 8'h00, 32'h0,         4'hF, 8'h00, 32'h0};
    vt[8]  = '{1'b1, 8'h04, 32'h1,         4'h1, 8'h04, 32'h0};
    vt[9]  = '{1'b0, 8'h18, 32'h0,         4'h0, 8'h18, 32'h0};
    vt[10] = '{1'b0, 8'h00, 32'h0,         4'h0, 8'h34, 32'hFF34_FF78};
    vt[11] = '{1'b1, 8'h00, 32'h1,         4'h0, 8'h00, 32'h0};
    cyc();
    cyc();
    chk("rst_rdata", io_rdata, 0);
    chk("rst_irq", irq, 0);
    chk("rst_tick", tick, 0);
    rst = 0;
    cyc();
    for (int i = 0; i < 12; i++) begin
      if (vt[i].wen) wr(vt[i].waddr, vt[i].wdata, vt[i].wstrb);
      rd(vt[i].raddr, vt[i].exp, $sformatf("vec%0d", i));
    end
    // one-shot: prescale 3, count 2 -> expiry on the third tick
    wr(8'h08, 3, 4'hF);
    wr(8'h10, 2, 4'hF);
    wr(8'h00, 5, 4'hF);
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      chk($sformatf("os_tick%0d", c), tick, (c % 4 == 0 && c <= 12));
      chk($sformatf("os_irq%0d", c), irq, (c == 13));
    end
    cyc();
    rd(8'h00, 32'h4, "os_ctrl");
    rd(8'h10, 32'h0, "os_count");
    rd(8'h04, 32'h1, "os_status");
    wr(8'h04, 1, 4'h1);
    @(negedge clk);
    chk("os_irq_clr", irq, 0);
    chk("os_no_tick", tick, 0);
    cyc();
    rd(8'h04, 32'h0, "os_status_clr");
    // periodic: load 1, prescale 0 -> expiry every second cycle
    wr(8'h0C, 1, 4'hF);
    wr(8'h10, 1, 4'hF);
    wr(8'h08, 0, 4'hF);
    wr(8'h00, 3, 4'hF);
    rd(8'h10, 1, "per_cnt1");
    rd(8'h10, 0, "per_cnt2");
    rd(8'h10, 1, "per_cnt3");
    rd(8'h10, 0, "per_cnt4");
    wr(8'h04, 1, 4'h1);
    rd(8'h04, 0, "per_w1c");
    rd(8'h04, 1, "per_reset");
    wr(8'h04, 1, 4'h1);
    rd(8'h04, 1, "per_w1c_race");
    @(negedge clk);
    chk("per_irq_masked", irq, 0);
    cyc();
    wr(8'h00, 0, 4'hF);
    // software COUNT write beats a same-cycle tick
    wr(8'h10, 32'h50, 4'hF);
    wr(8'h00, 1, 4'hF);
    wr(8'h10, 32'h100, 4'hF);
    rd(8'h10, 32'h100, "col_cnt0");
    rd(8'h10, 32'hFF, "col_cnt1");
    rd(8'h10, 32'hFE, "col_cnt2");
    @(negedge clk);
    chk("col_tick", tick, 1);
    cyc();
    wr(8'h00, 0, 4'hF);
    // read latency and read-during-write
    wr(8'h08, 32'h42, 4'hF);
    rd(8'h14, 32'hFF34_FF78, "lat_scratch");
    rd(8'h08, 32'h42, "lat_prescale");
    io_raddr = 8'h14; rd_req = 1;
    exp_q.push_back(32'hFF34_FF78);
    nm_q.push_back("rdw_old");
    wr(8'h14, 32'hA5A5_A5A5, 4'hF);
    rd_req = 0;
    rd(8'h14, 32'hA5A5_A5A5, "rdw_new");
    // async reset while counting with irq asserted
    wr(8'h0C, 0, 4'hF);
    wr(8'h10, 0, 4'hF);
    wr(8'h08, 0, 4'hF);
    wr(8'h00, 7, 4'hF);
    cyc();
    @(negedge clk);
    chk("pre_rst_irq", irq, 1);
    chk("pre_rst_tick", tick, 1);
    #2 rst = 1;
    #1;
    chk("async_irq", irq, 0);
    chk("async_tick", tick, 0);
    chk("async_rdata", io_rdata, 0);
    cyc();
    cyc();
    rst = 0;
    for (int i = 0; i < 8; i++) rd(8'(i * 4), 32'h0, $sformatf("post_rst%0d", i));
    @(negedge clk);
    chk("post_rst_tick", tick, 0);
    chk("post_rst_irq", irq, 0);
    cyc();
    cyc();
    chk("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
